// File: rtl/dds_pkg.sv
// Shared defaults, quadrant encoding and the quarter-sine table generator for the DDS waveform source.
package dds_pkg;

  localparam int ACC_W_DEF   = 32;
  localparam int PHASE_W_DEF = 10;
  localparam int DATA_W_DEF  = 12;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_t;

  // pi in Q30 fixed point
  localparam longint PI_Q30 = 64'sd3373259426;

  function automatic int mid_of(input int dw);
    return 1 << (dw - 1);
  endfunction

  localparam int MID = mid_of(DATA_W_DEF);

  // Quadrants 1 and 3 run the quarter table backwards.
  function automatic logic quad_mirror(input quad_t q);
    return (q == QUAD_1) || (q == QUAD_3);
  endfunction

  // Second half of the cycle is the negative lobe.
  function automatic logic quad_neg(input quad_t q);
    return (q == QUAD_2) || (q == QUAD_3);
  endfunction

  // round((2^(dw-1)-1) * sin(pi*(2k+1)/2^phase_w)) using a Q30 Taylor series.
  function automatic int rom_entry(input int k, input int phase_w, input int dw);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    x    = (PI_Q30 * longint'(2 * k + 1)) >>> phase_w;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n < 8; n++) begin
      term = -((term * x2) >>> 30) / longint'(4 * n * n + 2 * n);
      sum  = sum + term;
    end
    amp = (longint'(1) << (dw - 1)) - 1;
    return int'((amp * sum + (longint'(1) << 29)) >>> 30);
  endfunction

endpackage

// File: rtl/dds_quarter_rom.sv
// Dual-read quarter-wave sine table shared by the sin and cos paths.
// One-cycle registered read on both ports.
module dds_quarter_rom
  import dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PHASE_W-3:0] addr_a,
  input  logic [PHASE_W-3:0] addr_b,
  output logic [DATA_W-2:0]  dat_a,
  output logic [DATA_W-2:0]  dat_b
);

  localparam int DEPTH = 1 << (PHASE_W - 2);

  logic [DATA_W-2:0] tbl [DEPTH];

  // Half-sample offset keeps the table exactly symmetric under address mirroring.
  for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
    assign tbl[k] = (DATA_W - 1)'(rom_entry(k, PHASE_W, DATA_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_a <= '0;
      dat_b <= '0;
    end else begin
      dat_a <= tbl[addr_a];
      dat_b <= tbl[addr_b];
    end
  end

endmodule

// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS producing offset-binary cos/sin/square/triangle from one tuning word.
// Three-stage pipeline after the accumulator; all outputs aligned, dout_valid tracks en.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [ACC_W-1:0]   fword,
  input  logic [PHASE_W-1:0] pword,
  input  logic               phase_clr,
  output logic [DATA_W-1:0]  cos,
  output logic [DATA_W-1:0]  sin,
  output logic [DATA_W-1:0]  square,
  output logic [DATA_W-1:0]  triangular,
  output logic               dout_valid
);

  localparam int AW      = PHASE_W - 2;
  localparam int TRI_PAD = DATA_W - (PHASE_W - 1);
  localparam logic [DATA_W-1:0]  MID_C = DATA_W'(mid_of(DATA_W));
  localparam logic [PHASE_W-1:0] QTR   = PHASE_W'(1) << AW;

  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   fword_r;
  logic [PHASE_W-1:0] pword_r;

  logic [PHASE_W-1:0] ph_s1;
  logic [PHASE_W-1:0] phc;
  quad_t              q_sin;
  quad_t              q_cos;
  logic [AW-1:0]      addr_sin;
  logic [AW-1:0]      addr_cos;

  logic [DATA_W-2:0]  mag_sin;
  logic [DATA_W-2:0]  mag_cos;
  logic               neg_sin_s2;
  logic               neg_cos_s2;
  logic               sq_s2;
  logic [PHASE_W-2:0] tri_s2;
  logic [2:0]         vld_sr;

  // A same-cycle accumulate still sees the previous fword_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      fword_r <= '0;
      pword_r <= '0;
    end else begin
      if (cfg_load) begin
        fword_r <= fword;
        pword_r <= pword;
      end
      if (phase_clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc + fword_r;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_s1 <= '0;
    end else begin
      ph_s1 <= acc[ACC_W-1 -: PHASE_W] + pword_r;
    end
  end

  always_comb begin
    phc      = ph_s1 + QTR;
    q_sin    = quad_t'(ph_s1[PHASE_W-1 -: 2]);
    q_cos    = quad_t'(phc[PHASE_W-1 -: 2]);
    addr_sin = quad_mirror(q_sin) ? ~ph_s1[AW-1:0] : ph_s1[AW-1:0];
    addr_cos = quad_mirror(q_cos) ? ~phc[AW-1:0]   : phc[AW-1:0];
  end

  dds_quarter_rom #(
    .PHASE_W (PHASE_W),
    .DATA_W  (DATA_W)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_a (addr_sin),
    .addr_b (addr_cos),
    .dat_a  (mag_sin),
    .dat_b  (mag_cos)
  );

  // Side-band S2 state travels with the ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_sin_s2 <= 1'b0;
      neg_cos_s2 <= 1'b0;
      sq_s2      <= 1'b0;
      tri_s2     <= '0;
    end else begin
      neg_sin_s2 <= quad_neg(q_sin);
      neg_cos_s2 <= quad_neg(q_cos);
      sq_s2      <= ph_s1[PHASE_W-1];
      tri_s2     <= ph_s1[PHASE_W-1] ? ~ph_s1[PHASE_W-2:0] : ph_s1[PHASE_W-2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin        <= '0;
      cos        <= '0;
      square     <= '0;
      triangular <= '0;
    end else begin
      sin        <= neg_sin_s2 ? MID_C - DATA_W'(mag_sin) : MID_C + DATA_W'(mag_sin);
      cos        <= neg_cos_s2 ? MID_C - DATA_W'(mag_cos) : MID_C + DATA_W'(mag_cos);
      square     <= sq_s2 ? '0 : '1;
      triangular <= DATA_W'(tri_s2) << TRI_PAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[1:0], en};
    end
  end

  assign dout_valid = vld_sr[2];

endmodule

// File: tb/tb_dds_wave_gen.sv
// Randomized bench for dds_wave_gen against a trig-based reference model with 3-cycle alignment.
`timescale 1ns/1ps
module tb_dds_wave_gen;
  import dds_pkg::*;

  localparam real PI_R = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        cfg_load = 1'b0;
  logic        phase_clr = 1'b0;
  logic [31:0] fword = '0;
  logic [9:0]  pword = '0;
  logic [11:0] w_cos;
  logic [11:0] w_sin;
  logic [11:0] w_sq;
  logic [11:0] w_tri;
  logic        w_vld;

  int n_vec = 0;
  int n_err = 0;

  longint m_acc = 0;
  longint m_fw  = 0;
  int     m_pw  = 0;
  int     q_ph[$];
  int     q_vld[$];

  always #5 clk = ~clk;

  dds_wave_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_load   (cfg_load),
    .fword      (fword),
    .pword      (pword),
    .phase_clr  (phase_clr),
    .cos        (w_cos),
    .sin        (w_sin),
    .square     (w_sq),
    .triangular (w_tri),
    .dout_valid (w_vld)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wave_code(input real v);
    int mag;
    mag = $rtoi($floor(((v < 0.0) ? -v : v) + 0.5));
    return (v < 0.0) ? MID - mag : MID + mag;
  endfunction

  task automatic model_reset();
    m_acc = 0;
    m_fw  = 0;
    m_pw  = 0;
    q_ph.delete();
    q_vld.delete();
  endtask

  task automatic check_outputs();
    int  ph_e;
    int  v_e;
    real ang;
    ph_e = 0;
    v_e  = 0;
    if (q_ph.size() == 3) begin
      ph_e = q_ph.pop_front();
      v_e  = q_vld.pop_front();
    end
    chk("dout_valid", int'(w_vld), v_e);
    if (v_e != 0) begin
      ang = 2.0 * PI_R * (real'(ph_e) + 0.5) / 1024.0;
      chk("sin", int'(w_sin), wave_code(2047.0 * $sin(ang)));
      chk("cos", int'(w_cos), wave_code(2047.0 * $cos(ang)));
      chk("square", int'(w_sq), (ph_e < 512) ? 4095 : 0);
      chk("triangular", int'(w_tri), ((ph_e < 512) ? ph_e : 1023 - ph_e) * 8);
      if (ph_e == 256)  chk("sin_ph256", int'(w_sin), 4095);
      if (ph_e == 768)  chk("sin_ph768", int'(w_sin), 1);
      if (ph_e == 0)    chk("cos_ph0", int'(w_cos), 4095);
      if (ph_e == 0)    chk("tri_ph0", int'(w_tri), 0);
      if (ph_e == 511)  chk("tri_ph511", int'(w_tri), 4088);
      if (ph_e == 512)  chk("tri_ph512", int'(w_tri), 4088);
      if (ph_e == 1023) chk("tri_ph1023", int'(w_tri), 0);
      if (ph_e == 511)  chk("sq_ph511", int'(w_sq), 4095);
      if (ph_e == 512)  chk("sq_ph512", int'(w_sq), 0);
    end
  endtask

  // Inputs are set at the negedge; the model consumes them at the posedge.
  task automatic step();
    @(posedge clk);
    q_ph.push_back(int'(((m_acc >> 22) + longint'(m_pw)) % 1024));
    q_vld.push_back(int'(en));
    if (phase_clr)
      m_acc = 0;
    else if (en)
      m_acc = (m_acc + m_fw) % 64'h1_0000_0000;
    if (cfg_load) begin
      m_fw = longint'(fword);
      m_pw = int'(pword);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sin"}, int'(w_sin), 0);
    chk({tag, "_cos"}, int'(w_cos), 0);
    chk({tag, "_sq"}, int'(w_sq), 0);
    chk({tag, "_tri"}, int'(w_tri), 0);
    chk({tag, "_vld"}, int'(w_vld), 0);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero(tag);
    en = 1'b0; cfg_load = 1'b0; phase_clr = 1'b0;
    @(negedge clk);
    check_all_zero({tag, "_hold"});
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    pulse_reset("rst_init");

    // Ramp at one phase step per cycle through a full period.
    cfg_load = 1'b1; fword = 32'h0040_0000; pword = 10'd0;
    step();
    cfg_load = 1'b0; phase_clr = 1'b1; en = 1'b1;
    step();
    phase_clr = 1'b0;
    repeat (1030) step();

    // Static phase: constant outputs, valid rises exactly three cycles after en.
    en = 1'b0; cfg_load = 1'b1; fword = '0; pword = 10'd256;
    step();
    cfg_load = 1'b0; phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    repeat (4) step();
    en = 1'b1;
    step(); chk("vld_lat1", int'(w_vld), 0);
    step(); chk("vld_lat2", int'(w_vld), 0);
    step(); chk("vld_lat3", int'(w_vld), 1);
    chk("sin_const", int'(w_sin), 4095);
    repeat (5) step();
    chk("sin_const_hold", int'(w_sin), 4095);

    // New tuning word loaded while stepping.
    cfg_load = 1'b1; fword = 32'h0100_0000;
    step();
    cfg_load = 1'b0;
    repeat (8) step();

    // Clear and step together.
    phase_clr = 1'b1; en = 1'b1;
    step();
    phase_clr = 1'b0;
    repeat (6) step();

    for (int i = 0; i < 200; i++) begin
      en = ($urandom_range(0, 3) != 0);
      step();
    end

    pulse_reset("rst_mid");
    repeat (3) step();
    cfg_load = 1'b1; fword = $urandom; pword = 10'($urandom);
    step();
    cfg_load = 1'b0; en = 1'b1;
    repeat (6) step();

    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      phase_clr = ($urandom_range(0, 31) == 0);
      cfg_load  = ($urandom_range(0, 19) == 0);
      fword     = $urandom;
      pword     = 10'($urandom);
      step();
    end
    en = 1'b0; cfg_load = 1'b0; phase_clr = 1'b0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
